// File: rtl/video_axi_read_arbiter_if.sv
// video_axi_read_arbiter_if: bus bundle around the video read arbiter.
// Carries both requester AR/R channels (s0_*, s1_*) and the shared AXI4 read master (axi_*).
// Modports:
//   slave  - the arbiter's view (takes requests, drives the AXI master side)
//   master - the surrounding system's view (requesters plus interconnect)
interface video_axi_read_arbiter_if;
    logic        s0_ar_valid, s0_ar_ready, s0_r_valid, s0_r_ready, s0_r_last;
    logic [31:0] s0_ar_addr, s0_r_data;
    logic [7:0]  s0_ar_len;
    logic        s1_ar_valid, s1_ar_ready, s1_r_valid, s1_r_ready, s1_r_last;
    logic [31:0] s1_ar_addr, s1_r_data;
    logic [7:0]  s1_ar_len;
    logic        axi_ar_valid, axi_ar_ready, axi_r_valid, axi_r_ready, axi_r_payload_last;
    logic [31:0] axi_ar_payload_addr, axi_r_payload_data;
    logic [7:0]  axi_ar_payload_len;
    logic [1:0]  axi_ar_payload_burst;
    modport slave (
        input  s0_ar_valid, s0_ar_addr, s0_ar_len, s0_r_ready,
        input  s1_ar_valid, s1_ar_addr, s1_ar_len, s1_r_ready,
        input  axi_ar_ready, axi_r_valid, axi_r_payload_data, axi_r_payload_last,
        output s0_ar_ready, s0_r_valid, s0_r_data, s0_r_last,
        output s1_ar_ready, s1_r_valid, s1_r_data, s1_r_last,
        output axi_ar_valid, axi_ar_payload_addr, axi_ar_payload_len, axi_ar_payload_burst, axi_r_ready
    );
    modport master (
        output s0_ar_valid, s0_ar_addr, s0_ar_len, s0_r_ready,
        output s1_ar_valid, s1_ar_addr, s1_ar_len, s1_r_ready,
        output axi_ar_ready, axi_r_valid, axi_r_payload_data, axi_r_payload_last,
        input  s0_ar_ready, s0_r_valid, s0_r_data, s0_r_last,
        input  s1_ar_ready, s1_r_valid, s1_r_data, s1_r_last,
        input  axi_ar_valid, axi_ar_payload_addr, axi_ar_payload_len, axi_ar_payload_burst, axi_r_ready
    );
endinterface

// File: rtl/video_axi_read_arbiter.sv
// video_axi_read_arbiter: shares one AXI4 INCR read master between the video fetcher (s0) and a DMA/CPU reader (s1).
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   bus        - video_axi_read_arbiter_if.slave: s0/s1 requester AR+R channels and the AXI read master
//   busy       - high whenever a burst is being issued or received
// Optional macro VIDEO_ARB_STATS_EN adds parameter CNT_W and outputs
//   stat_s0_bursts, stat_s1_bursts (saturating grant counts) and stat_s1_wait_max (longest s1 wait in cycles).
// One burst is in flight at a time; s0 has priority, but after MAX_HP_BURSTS back-to-back s0 grants
// with s1 waiting, s1 wins the next arbitration.
module video_axi_read_arbiter #(
    parameter int MAX_HP_BURSTS = 4
`ifdef VIDEO_ARB_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic clk,
    input  logic reset,
    video_axi_read_arbiter_if.slave bus,
    output logic busy
`ifdef VIDEO_ARB_STATS_EN
    , output logic [CNT_W-1:0] stat_s0_bursts,
    output logic [CNT_W-1:0] stat_s1_bursts,
    output logic [CNT_W-1:0] stat_s1_wait_max
`endif
);
    localparam int HW = $clog2(MAX_HP_BURSTS + 1);
    localparam logic [HW-1:0] HP_MAX = HW'(MAX_HP_BURSTS);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state;
    logic owner;
    logic [HW-1:0] hp_run;
    logic idle, data, grant0, grant1, own_ready;
    // Handshake outputs are suppressed while reset is held so nothing is accepted or forwarded.
    assign idle = state == IDLE && !reset;
    assign data = state == DATA && !reset;
    assign grant1 = idle && bus.s1_ar_valid && (!bus.s0_ar_valid || hp_run == HP_MAX);
    assign grant0 = idle && bus.s0_ar_valid && !grant1;
    assign own_ready = owner ? bus.s1_r_ready : bus.s0_r_ready;
    assign busy = state != IDLE;
    assign bus.s0_ar_ready = grant0;
    assign bus.s1_ar_ready = grant1;
    // R beats outside DATA are protocol errors: never forwarded, never accepted.
    assign bus.s0_r_valid = data && !owner && bus.axi_r_valid;
    assign bus.s1_r_valid = data && owner && bus.axi_r_valid;
    assign bus.axi_r_ready = data && own_ready;
    assign bus.s0_r_data = bus.axi_r_payload_data;
    assign bus.s1_r_data = bus.axi_r_payload_data;
    assign bus.s0_r_last = bus.axi_r_payload_last;
    assign bus.s1_r_last = bus.axi_r_payload_last;
    assign bus.axi_ar_payload_burst = 2'd1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            hp_run <= '0;
            bus.axi_ar_valid <= 1'b0;
            bus.axi_ar_payload_addr <= '0;
            bus.axi_ar_payload_len <= '0;
        end else begin
            case (state)
                IDLE: if (grant0 || grant1) begin
                    state <= ADDR;
                    owner <= grant1;
                    bus.axi_ar_valid <= 1'b1;
                    bus.axi_ar_payload_addr <= grant1 ? bus.s1_ar_addr : bus.s0_ar_addr;
                    bus.axi_ar_payload_len <= grant1 ? bus.s1_ar_len : bus.s0_ar_len;
                    // hp_run counts s0 wins only while s1 is actually waiting.
                    hp_run <= (grant1 || !bus.s1_ar_valid) ? '0 : hp_run + HW'(hp_run != HP_MAX);
                end
                ADDR: if (bus.axi_ar_ready) begin
                    bus.axi_ar_valid <= 1'b0;
                    state <= DATA;
                end
                DATA: if (bus.axi_r_valid && bus.axi_r_ready && bus.axi_r_payload_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef VIDEO_ARB_STATS_EN
    logic [CNT_W-1:0] wait_run, wait_nxt;
    assign wait_nxt = (bus.s1_ar_valid && !grant1) ? wait_run + CNT_W'(~&wait_run) : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_s0_bursts <= '0;
            stat_s1_bursts <= '0;
            stat_s1_wait_max <= '0;
            wait_run <= '0;
        end else begin
            stat_s0_bursts <= stat_s0_bursts + CNT_W'(grant0 && ~&stat_s0_bursts);
            stat_s1_bursts <= stat_s1_bursts + CNT_W'(grant1 && ~&stat_s1_bursts);
            wait_run <= wait_nxt;
            if (wait_nxt > stat_s1_wait_max) stat_s1_wait_max <= wait_nxt;
        end
    end
`endif
endmodule

// File: doc/video_axi_read_arbiter.md
Name: video_axi_read_arbiter

Overview:
- Shares one AXI4 read master port (INCR bursts) between two requesters: requester 0, the real-time video line fetcher, and requester 1, a general-purpose DMA/CPU reader.
- At most one burst is in flight at a time. The R beats of that burst are routed back to the requester that owns the grant.
- Requester 0 has fixed priority. A starvation guard gives requester 1 a guaranteed slot.
- Sits between the video controller and the system AXI interconnect, in the clk domain.

Parameters:
- MAX_HP_BURSTS, default 4: maximum number of consecutive requester-0 grants while requester 1 is waiting, after which requester 1 wins the next arbitration.
- CNT_W, default 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s0_ar_valid  in  1  requester 0 address valid.
- s0_ar_ready  out  1  requester 0 address accepted.
- s0_ar_addr  in  32  requester 0 burst address.
- s0_ar_len  in  8  requester 0 burst length minus 1.
- s0_r_valid  out  1  requester 0 read beat valid.
- s0_r_ready  in  1  requester 0 read beat ready.
- s0_r_data  out  32  requester 0 read data.
- s0_r_last  out  1  requester 0 last beat.
- s1_ar_valid, s1_ar_ready, s1_ar_addr, s1_ar_len, s1_r_valid, s1_r_ready, s1_r_data, s1_r_last: same directions and widths as the s0_* ports, for requester 1.
- axi_ar_valid  out  1  master address valid.
- axi_ar_ready  in  1  master address ready.
- axi_ar_payload_addr  out  32  master burst address.
- axi_ar_payload_len  out  8  master burst length.
- axi_ar_payload_burst  out  2  constant 2'd1 (INCR).
- axi_r_valid  in  1  master read beat valid.
- axi_r_ready  out  1  master read beat ready.
- axi_r_payload_data  in  32  master read data.
- axi_r_payload_last  in  1  master last beat.
- busy  out  1  high when not in IDLE.

Behaviour:
- FSM has three states: IDLE, ADDR, DATA. Reset forces IDLE.
- Reset values: owner=0, hp_run=0, axi_ar_valid=0, busy=0. All s*_ar_ready and s*_r_valid are 0. axi_r_ready is 0 in IDLE.
- IDLE, arbitration:
  - If s1 is valid and (s0 is not valid or hp_run==MAX_HP_BURSTS): grant s1, hp_run<=0.
  - Else if s0 is valid: grant s0. If s1 is valid, hp_run<=hp_run+1 (saturating); otherwise hp_run<=0.
  - On a grant: latch owner, addr and len into axi_ar_payload_*; assert s<owner>_ar_ready for exactly this one cycle; go to ADDR with axi_ar_valid=1.
  - Latency from request to axi_ar_valid is one cycle.
- Requester handshake rules:
  - A requester must hold ar_valid, addr and len stable until it sees ar_ready.
  - A requester that drops ar_valid before being granted is simply not granted. This is legal.
- ADDR: hold axi_ar_valid and the payload stable until axi_ar_ready. On axi_ar_valid & axi_ar_ready: axi_ar_valid<=0, go to DATA.
- DATA, combinational routing:
  - s<owner>_r_valid = axi_r_valid; s<owner>_r_data and s<owner>_r_last are driven from the master R channel.
  - axi_r_ready = s<owner>_r_ready.
  - The non-owner's r_valid is 0. Its r_data may carry the same data.
  - On a beat with axi_r_valid & axi_r_ready & axi_r_payload_last: go to IDLE. Re-arbitration happens in that IDLE cycle, so consecutive bursts are separated by at least one idle cycle.
- R beats arriving in IDLE or ADDR are protocol errors. They are not forwarded, and axi_r_ready is 0.
- Simultaneous requests with hp_run<MAX_HP_BURSTS: s0 wins.
- The hp_run counter width is clog2(MAX_HP_BURSTS+1). It saturates and does not wrap.
- Reset mid-burst: return to IDLE immediately and drop axi_ar_valid. The system resets the interconnect together with this block, so stale R beats are not expected after reset.
- busy = (state != IDLE).

Optional Feature:
- Macro: VIDEO_ARB_STATS_EN.
- When defined, the block adds outputs stat_s0_bursts, stat_s1_bursts and stat_s1_wait_max, each CNT_W bits.
  - stat_s0_bursts and stat_s1_bursts count accepted grants per requester and saturate at all-ones.
  - stat_s1_wait_max records the longest run of cycles with s1_ar_valid high and no s1 grant.
  - All three counters clear on reset.
- When not defined, these ports and their logic do not exist, and arbitration behaviour is identical.

Test Plan:
- Single s0 request, addr=0x1000, len=63, axi_ar_ready=1 -> axi_ar_valid one cycle later with the same payload; 64 beats routed to s0; s0_r_last on beat 64; busy back to 0 on the next cycle.
- s0 and s1 both asserted continuously, MAX_HP_BURSTS=4 -> grant order s0,s0,s0,s0,s1,s0,s0,s0,s0,s1...
- Only s1 requests, len=0 -> one beat to s1; s0_r_valid stays 0 throughout.
- axi_ar_ready held low for 10 cycles -> payload and axi_ar_valid stable all 10 cycles; no s*_ar_ready pulse beyond the grant cycle.
- Owner s0 deasserts s0_r_ready for 5 cycles mid-burst -> axi_r_ready low for those same 5 cycles; no beat lost or duplicated (scoreboard matches all 64 words).
- Reset asserted in DATA after 10 of 64 beats -> next cycle state is IDLE, axi_ar_valid=0, hp_run=0; with VIDEO_ARB_STATS_EN defined, all counters read 0.
